// File: rtl/readout_pkg.sv
// Shared types and constants for the ROI readout scheduler slice.
package readout_pkg;

  localparam int MAX_SITES = 128;
  localparam int RAM_LAT   = 1;
  localparam int ENG_LAT   = 4;
  localparam int CNT_W     = 8;
  // Outstanding counter needs room for ENG_LAT+1 in flight plus headroom.
  localparam int OUT_W     = $clog2(ENG_LAT + 2) + 1;

  typedef logic [6:0]  site_id_t;
  typedef logic [71:0] roi_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

  function automatic logic [CNT_W-1:0] clamp_sites(input logic [CNT_W-1:0] n);
    return (n > CNT_W'(MAX_SITES)) ? CNT_W'(MAX_SITES) : n;
  endfunction

endpackage

// File: rtl/roi_fetch_delay.sv
// Valid+id shift register that tracks ROI RAM reads until the data word appears.
module roi_fetch_delay
  import readout_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [6:0] i_id,
  output logic       o_valid,
  output logic [6:0] o_id,
  output logic       o_any
);

  logic [DEPTH-1:0] vld_sr;
  site_id_t         id_sr [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_sr <= '0;
      for (int i = 0; i < DEPTH; i++) id_sr[i] <= '0;
    end else begin
      vld_sr[0] <= i_valid;
      id_sr[0]  <= i_id;
      for (int i = 1; i < DEPTH; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        id_sr[i]  <= id_sr[i-1];
      end
    end
  end

  assign o_valid = vld_sr[DEPTH-1];
  assign o_id    = id_sr[DEPTH-1];
  assign o_any   = |vld_sr;

endmodule

// File: rtl/roi_readout_scheduler.sv
// Per-shot sequencer: walks atom sites, feeds ROIs to the filter engine and
// gathers the per-site decisions into an occupancy bitmap for downstream logic.
module roi_readout_scheduler
  import readout_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic [7:0]   i_num_sites,
  output logic         o_ram_rd_en,
  output logic [6:0]   o_ram_addr,
  input  logic [71:0]  i_ram_rdata,
  output logic         o_eng_valid,
  output logic [71:0]  o_eng_roi,
  output logic [6:0]   o_eng_id,
  input  logic         i_eng_valid,
  input  logic         i_eng_decision,
  input  logic [6:0]   i_eng_id,
  output logic         o_res_valid,
  input  logic         i_res_ready,
  output logic [127:0] o_res_bitmap,
  output logic [7:0]   o_res_count,
  output logic         o_busy,
  output logic         o_err
);

  // Result handshake: o_res_valid rises on entry to DONE and holds with the
  // bitmap/count stable until a cycle where i_res_ready is also high.
  state_e           state;
  logic [CNT_W-1:0] site_cnt;
  logic [CNT_W-1:0] n_lat;
  logic [OUT_W-1:0] outstanding;
  logic             dly_any;
  logic             drained;
  logic             collecting;
  logic             id_ok;
  logic [CNT_W-1:0] n_clamped;

  roi_fetch_delay #(.DEPTH(RAM_LAT)) u_fetch_delay (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (o_ram_rd_en),
    .i_id    (o_ram_addr),
    .o_valid (o_eng_valid),
    .o_id    (o_eng_id),
    .o_any   (dly_any)
  );

  // RAM data lines up with the delay-line output, so it goes straight through.
  assign o_eng_roi  = i_ram_rdata;
  assign o_busy     = (state != ST_IDLE);
  assign n_clamped  = clamp_sites(i_num_sites);
  assign drained    = (outstanding == '0) && !dly_any && !o_ram_rd_en;
  assign collecting = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign id_ok      = ({1'b0, i_eng_id} < n_lat);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      site_cnt    <= '0;
      n_lat       <= '0;
      o_ram_rd_en <= 1'b0;
      o_ram_addr  <= '0;
      o_res_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            n_lat <= n_clamped;
            if (n_clamped == '0) begin
              state       <= ST_DONE;
              o_res_valid <= 1'b1;
            end else begin
              state       <= ST_ISSUE;
              o_ram_rd_en <= 1'b1;
              o_ram_addr  <= '0;
              site_cnt    <= CNT_W'(1);
            end
          end
        end
        ST_ISSUE: begin
          if (i_abort) begin
            state       <= ST_FLUSH;
            o_ram_rd_en <= 1'b0;
          end else if (site_cnt == n_lat) begin
            state       <= ST_DRAIN;
            o_ram_rd_en <= 1'b0;
          end else begin
            o_ram_rd_en <= 1'b1;
            o_ram_addr  <= site_cnt[6:0];
            site_cnt    <= site_cnt + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (i_abort) begin
            state <= ST_FLUSH;
          end else if (drained) begin
            state       <= ST_DONE;
            o_res_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (i_res_ready) begin
            state       <= ST_IDLE;
            o_res_valid <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (drained) state <= ST_IDLE;
        end
        default: begin
          state       <= ST_IDLE;
          o_ram_rd_en <= 1'b0;
          o_res_valid <= 1'b0;
        end
      endcase
    end
  end

  // Decrement saturates so a stray result cannot wrap the in-flight count.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      outstanding <= '0;
    end else if (o_eng_valid && !i_eng_valid) begin
      outstanding <= outstanding + OUT_W'(1);
    end else if (!o_eng_valid && i_eng_valid && (outstanding != '0)) begin
      outstanding <= outstanding - OUT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_res_bitmap <= '0;
      o_res_count  <= '0;
      o_err        <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (i_start) begin
        o_res_bitmap <= '0;
        o_res_count  <= '0;
        o_err        <= 1'b0;
      end else if (i_eng_valid) begin
        o_err <= 1'b1;
      end
    end else if (collecting && i_eng_valid) begin
      if (id_ok) begin
        o_res_bitmap[i_eng_id] <= i_eng_decision;
        o_res_count            <= o_res_count + {7'b0, i_eng_decision};
      end else begin
        o_err <= 1'b1;
      end
    end
  end

endmodule
